fetch_sequencer: RTL and testbench

- Instruction-fetch control stage wrapped around program_counter in the KGPMini RISC processor.
- Consumes the PC register output (pc_in) and issues an instruction-memory read for that address.
- Holds the returned word in an output register for the decode stage, using a valid/ready handshake.
- Produces next_pc, which feeds the program_counter next input. program_counter loads every clock and has no enable, so this block stalls it by driving next_pc = pc_in.

---
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control stage for the KGPMini core.
// Issues one instruction-memory read per PC value, holds the returned word
// for decode under a valid/ready handshake, and steers the external program
// counter through next_pc (holding it by feeding pc_in back when stalled).
module fetch_sequencer #(
   parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   output logic [31:0] next_pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        valid_q, valid_d;

   // Redirect targets are word aligned; the low bits are dropped.
   logic [1:0]  unused_tgt_lsb;
   assign unused_tgt_lsb = branch_target[1:0];

   // Sequential PC step; wraps naturally at 2^32.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign imem_addr   = addr_q;
   assign instr_out   = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = valid_q;

   // PC steering: redirect first, advance only when the fetched word lands.
   always_comb begin
      next_pc = pc_in;
      if (branch_taken) begin
         next_pc = {branch_target[31:2], 2'b00};
      end else if ((state_q == ST_FETCH) && imem_ack) begin
         next_pc = pc_plus4(pc_in);
      end
   end

   // Next-state and datapath-load decisions for the fetch FSM.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      // A redirect always kills the held instruction, ready notwithstanding.
      if (branch_taken) begin
         valid_d = 1'b0;
      end
      unique case (state_q)
         ST_ISSUE: begin
            if (branch_taken) begin
               // pc_in is stale this cycle; wait for the redirected PC.
               state_d = ST_ISSUE;
            end else begin
               addr_d  = pc_in;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (branch_taken) begin
               // Outstanding requests are never withdrawn: drain if not yet acked.
               state_d = imem_ack ? ST_ISSUE : ST_DRAIN;
            end else if (imem_ack) begin
               instr_d = imem_rdata;
               ipc_d   = addr_q;
               valid_d = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (branch_taken) begin
               state_d = ST_ISSUE;
            end else if (valid_q && instr_ready) begin
               valid_d = 1'b0;
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            // Wait out the stale request; its data is thrown away.
            if (!branch_taken && imem_ack) begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_ISSUE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_ISSUE;
         addr_q  <= 32'h0;
         instr_q <= RESET_INSTR;
         ipc_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a bench-side program counter and
// instruction memory surround the DUT; delivered instructions are compared
// against an expected queue filled as each scenario is set up.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_I = 32'hDEAD_BEEF;
   localparam logic [31:0] K     = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_q;
   logic [31:0] pc_in;
   logic [31:0] next_pc;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic [31:0] pc_reset_val = 32'h0;
   logic [31:0] exp_pc[$];
   logic [31:0] exp_ins[$];
   logic [31:0] obs_pc[$];
   logic [31:0] obs_ins[$];

   fetch_sequencer #(.RESET_INSTR(RST_I)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_in        (pc_in),
      .next_pc      (next_pc),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr_out    (instr_out),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready)
   );

   always #5 clk = ~clk;

   // program_counter: loads next_pc every edge, no enable.
   always @(posedge clk or posedge reset) begin
      if (reset) pc_q <= pc_reset_val;
      else       pc_q <= next_pc;
   end
   assign pc_in = pc_q;

   // Advance one cycle: record an accepted instruction, cross the edge,
   // then update the memory responder and settle.
   task automatic tick();
      if (!reset && instr_valid && instr_ready && !branch_taken) begin
         obs_pc.push_back(instr_pc);
         obs_ins.push_back(instr_out);
      end
      @(negedge clk);
      if (reset || !imem_req) begin
         mem_cnt    = 0;
         imem_ack   = 1'b0;
         imem_rdata = 32'h0;
      end else begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ K;
            mem_cnt    = 0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
         end
      end
      #1;
   endtask

   task automatic run_until(input int n, input int budget);
      for (int i = 0; i < budget && obs_pc.size() < n; i++) tick();
   endtask

   task automatic apply_reset(input logic [31:0] pcv, input int lat, input logic rdy);
      pc_reset_val  = pcv;
      mem_lat       = lat;
      instr_ready   = rdy;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_pc.delete();
      exp_ins.delete();
      obs_pc.delete();
      obs_ins.delete();
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_out !== RST_I ||
          instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: req=%b addr=%h out=%h pc=%h vld=%b, want 0 0 %h 0 0",
                  imem_req, imem_addr, instr_out, instr_pc, instr_valid, RST_I);
      end
      n_tests++;
      if (next_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_next_pc: got %h want 00000000", next_pc);
      end
   endtask

   task automatic test_straight();
      logic [31:0] exp_np, prev_addr, e, o;
      logic        prev_req;
      apply_reset(32'h0, 1, 1'b1);
      for (int v = 0; v < 4; v++) begin
         exp_pc.push_back(32'(v * 4));
         exp_ins.push_back(32'(v * 4) ^ K);
      end
      prev_req = 1'b0;
      prev_addr = 32'h0;
      for (int i = 0; i < 40 && obs_pc.size() < 4; i++) begin
         exp_np = imem_ack ? pc_in + 32'd4 : pc_in;
         n_tests++;
         if (next_pc !== exp_np) begin
            n_fail++;
            $display("FAIL straight_next_pc: got %h want %h (ack=%b)", next_pc, exp_np, imem_ack);
         end
         if (prev_req && imem_req) begin
            n_tests++;
            if (imem_addr !== prev_addr) begin
               n_fail++;
               $display("FAIL straight_addr_stable: got %h want %h", imem_addr, prev_addr);
            end
         end
         prev_req  = imem_req;
         prev_addr = imem_addr;
         tick();
      end
      n_tests++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_fail++;
         $display("FAIL straight_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         e = exp_pc.pop_front(); o = obs_pc.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL straight_pc: got %h want %h", o, e); end
         e = exp_ins.pop_front(); o = obs_ins.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL straight_instr: got %h want %h", o, e); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hold_out, hold_pc, e, o;
      apply_reset(32'h0, 1, 1'b0);
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      n_tests++;
      if (instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_timeout: instr_valid=%b want 1", instr_valid);
      end
      hold_out = instr_out;
      hold_pc  = instr_pc;
      n_tests++;
      if (hold_pc !== 32'h0 || hold_out !== K) begin
         n_fail++;
         $display("FAIL bp_first: pc=%h out=%h want 00000000 %h", hold_pc, hold_out, K);
      end
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (instr_valid !== 1'b1 || instr_out !== hold_out || instr_pc !== hold_pc ||
             imem_req !== 1'b0 || pc_in !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_hold: vld=%b out=%h pc=%h req=%b pc_in=%h want 1 %h %h 0 00000004",
                     instr_valid, instr_out, instr_pc, imem_req, pc_in, hold_out, hold_pc);
         end
         tick();
      end
      instr_ready = 1'b1;
      exp_pc.push_back(32'h0);  exp_ins.push_back(K);
      exp_pc.push_back(32'h4);  exp_ins.push_back(32'h4 ^ K);
      run_until(2, 30);
      n_tests++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_fail++;
         $display("FAIL bp_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         e = exp_pc.pop_front(); o = obs_pc.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bp_pc: got %h want %h", o, e); end
         e = exp_ins.pop_front(); o = obs_ins.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bp_instr: got %h want %h", o, e); end
      end
   endtask

   task automatic test_branch_fetch();
      logic [31:0] e, o;
      apply_reset(32'h0, 3, 1'b1);
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL brf_fetch: req=%b ack=%b want 1 0", imem_req, imem_ack);
      end
      branch_taken  = 1'b1;
      branch_target = 32'h43;
      #1;
      n_tests++;
      if (next_pc !== 32'h40) begin
         n_fail++;
         $display("FAIL brf_next_pc: got %h want 00000040", next_pc);
      end
      tick();
      branch_taken = 1'b0;
      #1;
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_in !== 32'h40 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL brf_drain: req=%b addr=%h pc_in=%h vld=%b want 1 00000000 00000040 0",
                  imem_req, imem_addr, pc_in, instr_valid);
      end
      for (int i = 0; i < 10 && !imem_ack; i++) tick();
      n_tests++;
      if (imem_ack !== 1'b1 || next_pc !== 32'h40 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL brf_drain_ack: ack=%b next_pc=%h vld=%b want 1 00000040 0",
                  imem_ack, next_pc, instr_valid);
      end
      exp_pc.push_back(32'h40); exp_ins.push_back(32'h40 ^ K);
      run_until(1, 30);
      n_tests++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_fail++;
         $display("FAIL brf_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         e = exp_pc.pop_front(); o = obs_pc.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL brf_pc: got %h want %h", o, e); end
         e = exp_ins.pop_front(); o = obs_ins.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL brf_instr: got %h want %h", o, e); end
      end
   endtask

   task automatic test_branch_ack();
      logic [31:0] e, o;
      apply_reset(32'h0, 1, 1'b1);
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL bra_fetch: req=%b ack=%b want 1 1", imem_req, imem_ack);
      end
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      #1;
      n_tests++;
      if (next_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL bra_next_pc: got %h want 00000100", next_pc);
      end
      tick();
      branch_taken = 1'b0;
      #1;
      n_tests++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL bra_discard: vld=%b req=%b want 0 0", instr_valid, imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL bra_refetch: req=%b addr=%h want 1 00000100", imem_req, imem_addr);
      end
      exp_pc.push_back(32'h100); exp_ins.push_back(32'h100 ^ K);
      run_until(1, 30);
      n_tests++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_fail++;
         $display("FAIL bra_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         e = exp_pc.pop_front(); o = obs_pc.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bra_pc: got %h want %h", o, e); end
         e = exp_ins.pop_front(); o = obs_ins.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bra_instr: got %h want %h", o, e); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] e, o;
      apply_reset(32'hFFFF_FFFC, 1, 1'b1);
      tick();
      n_tests++;
      if (imem_ack !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || next_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_next_pc: ack=%b addr=%h next_pc=%h want 1 fffffffc 00000000",
                  imem_ack, imem_addr, next_pc);
      end
      exp_pc.push_back(32'hFFFF_FFFC); exp_ins.push_back(32'hFFFF_FFFC ^ K);
      run_until(1, 30);
      n_tests++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         e = exp_pc.pop_front(); o = obs_pc.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", o, e); end
         e = exp_ins.pop_front(); o = obs_ins.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", o, e); end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] e, o;
      // Held instruction is wiped by an asynchronous reset.
      apply_reset(32'h200, 1, 1'b0);
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
         n_fail++;
         $display("FAIL areset_held: vld=%b pc=%h want 1 00000200", instr_valid, instr_pc);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (instr_valid !== 1'b0 || instr_out !== RST_I || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_wait: vld=%b out=%h pc=%h req=%b want 0 %h 00000000 0",
                  instr_valid, instr_out, instr_pc, imem_req, RST_I);
      end
      tick();
      // Reset landing mid-FETCH drops the request before the next edge.
      mem_lat = 3;
      reset = 1'b0;
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL areset_prefetch: req=%b addr=%h want 1 00000200", imem_req, imem_addr);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_fetch: req=%b addr=%h vld=%b want 0 00000000 0",
                  imem_req, imem_addr, instr_valid);
      end
      tick();
      mem_lat = 1;
      reset = 1'b0;
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL areset_restart: req=%b addr=%h want 1 00000200", imem_req, imem_addr);
      end
      instr_ready = 1'b1;
      exp_pc.push_back(32'h200); exp_ins.push_back(32'h200 ^ K);
      run_until(1, 30);
      n_tests++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_fail++;
         $display("FAIL areset_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         e = exp_pc.pop_front(); o = obs_pc.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL areset_pc: got %h want %h", o, e); end
         e = exp_ins.pop_front(); o = obs_ins.pop_front();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL areset_instr: got %h want %h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_straight();
      test_backpressure();
      test_branch_fetch();
      test_branch_ack();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
